// File: rtl/arbitro_mem_principal.sv
// Round-robin arbiter/sequencer sharing the main memory between instruction fetch (A)
// and load/store (B); each transaction runs OCIOSO -> ACESSO -> RESPOSTA.
`timescale 1ns/1ps
module arbitro_mem_principal #(
    parameter int unsigned LARG_END     = 8,
    parameter int unsigned LARG_DADO    = 32,
    parameter int unsigned PROFUNDIDADE = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ReqA,
    input  logic                 EscritaA,
    input  logic [LARG_END-1:0]  EndA,
    input  logic [LARG_DADO-1:0] DadoEscritaA,
    input  logic                 ReqB,
    input  logic                 EscritaB,
    input  logic [LARG_END-1:0]  EndB,
    input  logic [LARG_DADO-1:0] DadoEscritaB,
    output logic                 AckA,
    output logic [LARG_DADO-1:0] DadoLidoA,
    output logic                 ErroA,
    output logic                 AckB,
    output logic [LARG_DADO-1:0] DadoLidoB,
    output logic                 ErroB,
    output logic                 Ocupado,
    output logic [LARG_END-1:0]  EndLeitura,
    output logic [LARG_END-1:0]  EndEscrita,
    output logic [LARG_DADO-1:0] DadoMemEscrita,
    output logic                 CTRLEscritaMem,
    input  logic [LARG_DADO-1:0] DadoMemoria
);

    // One extra bit so a depth equal to 2**LARG_END still compares correctly.
    localparam logic [LARG_END:0] PROF_LIM = (LARG_END + 1)'(PROFUNDIDADE);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    estado_t                estado_q, estado_d;
    logic                   ultimo_b_q, ultimo_b_d;
    logic                   grant_b_q, grant_b_d;
    logic                   escrita_q, escrita_d;
    logic                   erro_q, erro_d;
    logic [LARG_END-1:0]    end_q, end_d;
    logic [LARG_DADO-1:0]   dado_esc_q, dado_esc_d;
    logic                   ack_a_q, ack_a_d;
    logic                   ack_b_q, ack_b_d;
    logic                   erro_a_q, erro_a_d;
    logic                   erro_b_q, erro_b_d;
    logic [LARG_DADO-1:0]   dado_lido_a_q, dado_lido_a_d;
    logic [LARG_DADO-1:0]   dado_lido_b_q, dado_lido_b_d;
    logic                   ocupado_q, ocupado_d;

    logic                   sel_b;
    logic [LARG_END-1:0]    end_sel;
    logic [LARG_DADO-1:0]   dado_lido_novo;

    // B wins when alone, or on a tie when A was the last one served.
    assign sel_b          = ReqB & (~ReqA | ~ultimo_b_q);
    assign end_sel        = sel_b ? EndB : EndA;
    assign dado_lido_novo = erro_q ? '0 : DadoMemoria;

    always_comb begin
        estado_d      = estado_q;
        ultimo_b_d    = ultimo_b_q;
        grant_b_d     = grant_b_q;
        escrita_d     = escrita_q;
        erro_d        = erro_q;
        end_d         = end_q;
        dado_esc_d    = dado_esc_q;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        erro_a_d      = 1'b0;
        erro_b_d      = 1'b0;
        dado_lido_a_d = dado_lido_a_q;
        dado_lido_b_d = dado_lido_b_q;

        case (estado_q)
            OCIOSO: begin
                if (ReqA | ReqB) begin
                    estado_d   = ACESSO;
                    grant_b_d  = sel_b;
                    ultimo_b_d = sel_b;
                    escrita_d  = sel_b ? EscritaB : EscritaA;
                    end_d      = end_sel;
                    dado_esc_d = sel_b ? DadoEscritaB : DadoEscritaA;
                    erro_d     = ({1'b0, end_sel} >= PROF_LIM);
                end
            end
            ACESSO: begin
                // Read data is sampled at the same edge as the write: pre-write contents.
                estado_d = RESPOSTA;
                if (grant_b_q) begin
                    ack_b_d       = 1'b1;
                    erro_b_d      = erro_q;
                    dado_lido_b_d = dado_lido_novo;
                end else begin
                    ack_a_d       = 1'b1;
                    erro_a_d      = erro_q;
                    dado_lido_a_d = dado_lido_novo;
                end
            end
            RESPOSTA: estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase

        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            estado_q      <= OCIOSO;
            ultimo_b_q    <= 1'b1;
            grant_b_q     <= 1'b0;
            escrita_q     <= 1'b0;
            erro_q        <= 1'b0;
            end_q         <= '0;
            dado_esc_q    <= '0;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            erro_a_q      <= 1'b0;
            erro_b_q      <= 1'b0;
            dado_lido_a_q <= '0;
            dado_lido_b_q <= '0;
            ocupado_q     <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            ultimo_b_q    <= ultimo_b_d;
            grant_b_q     <= grant_b_d;
            escrita_q     <= escrita_d;
            erro_q        <= erro_d;
            end_q         <= end_d;
            dado_esc_q    <= dado_esc_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            erro_a_q      <= erro_a_d;
            erro_b_q      <= erro_b_d;
            dado_lido_a_q <= dado_lido_a_d;
            dado_lido_b_q <= dado_lido_b_d;
            ocupado_q     <= ocupado_d;
        end
    end

    // Write strobe is combinational so an asserted reset blocks the write in the same cycle.
    assign CTRLEscritaMem = (estado_q == ACESSO) & escrita_q & ~erro_q & ~RST;

    assign AckA           = ack_a_q;
    assign AckB           = ack_b_q;
    assign ErroA          = erro_a_q;
    assign ErroB          = erro_b_q;
    assign DadoLidoA      = dado_lido_a_q;
    assign DadoLidoB      = dado_lido_b_q;
    assign Ocupado        = ocupado_q;
    assign EndLeitura     = end_q;
    assign EndEscrita     = end_q;
    assign DadoMemEscrita = dado_esc_q;

endmodule
